// File: rtl/d_inst_queue.sv
`default_nettype none
// ============================================================================
// Module  : d_inst_queue
// Brief   : F->D instruction buffer; circular queue of {PC, instr} pairs with
//           the head entry presented pre-split into MIPS fields.
// Revision: 1.0 - initial release
// ============================================================================
module d_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    input  logic [PC_W-1:0]  f_pc,
    input  logic [31:0]      f_instr,
    output logic             f_ready,
    input  logic             d_stall,
    input  logic             flush,
    output logic             d_valid,
    output logic [PC_W-1:0]  d_pc,
    output logic [31:0]      d_instr,
    output logic [5:0]       d_op,
    output logic [4:0]       d_rs,
    output logic [4:0]       d_rt,
    output logic [4:0]       d_rd,
    output logic [4:0]       d_shamt,
    output logic [5:0]       d_func,
    output logic [15:0]      d_imm16,
    output logic [25:0]      d_imm26,
    output logic [31:0]      d_imm_sext,
    output logic [31:0]      d_imm_zext,
    output logic [CNT_W-1:0] count
);

    localparam int              PTR_W  = $clog2(DEPTH);
    localparam int              ENTRY_W = PC_W + 32;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [PC_W-1:0]    w_pc;
    logic [31:0]        w_instr;

    // Full/empty come from the occupancy count, so pointer equality is never ambiguous.
    assign f_ready = (r_count != c_full);
    assign d_valid = (r_count != '0);
    assign count   = r_count;

    assign w_push = f_valid & f_ready;
    assign w_pop  = d_valid & ~d_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale slots are masked by d_valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {f_pc, f_instr};
        end
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign w_pc    = d_valid ? w_head[ENTRY_W-1:32] : '0;
    assign w_instr = d_valid ? w_head[31:0] : '0;

    assign d_pc       = w_pc;
    assign d_instr    = w_instr;
    assign d_op       = w_instr[31:26];
    assign d_rs       = w_instr[25:21];
    assign d_rt       = w_instr[20:16];
    assign d_rd       = w_instr[15:11];
    assign d_shamt    = w_instr[10:6];
    assign d_func     = w_instr[5:0];
    assign d_imm16    = w_instr[15:0];
    assign d_imm26    = w_instr[25:0];
    assign d_imm_sext = {{16{w_instr[15]}}, w_instr[15:0]};
    assign d_imm_zext = {16'b0, w_instr[15:0]};

endmodule
`default_nettype wire

// File: tb/tb_d_inst_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_d_inst_queue
// Brief   : Scoreboard bench for d_inst_queue (DEPTH=4, PC_W=32).
// Revision: 1.0 - initial release
// ============================================================================
module tb_d_inst_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_ready;
    logic             d_stall;
    logic             flush;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic [5:0]       d_op;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_rd;
    logic [4:0]       d_shamt;
    logic [5:0]       d_func;
    logic [15:0]      d_imm16;
    logic [25:0]      d_imm26;
    logic [31:0]      d_imm_sext;
    logic [31:0]      d_imm_zext;
    logic [CNT_W-1:0] count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_count  = 0;
    logic [63:0] sb[$];

    d_inst_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
        .f_ready(f_ready), .d_stall(d_stall), .flush(flush), .d_valid(d_valid),
        .d_pc(d_pc), .d_instr(d_instr), .d_op(d_op), .d_rs(d_rs), .d_rt(d_rt),
        .d_rd(d_rd), .d_shamt(d_shamt), .d_func(d_func), .d_imm16(d_imm16),
        .d_imm26(d_imm26), .d_imm_sext(d_imm_sext), .d_imm_zext(d_imm_zext),
        .count(count)
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus and advances the reference queue accordingly.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
        bit          do_push;
        bit          do_pop;
        logic [63:0] dropped;
        f_valid = fv; f_pc = pc; f_instr = ins; d_stall = st; flush = fl;
        do_push = fv && (m_count != DEPTH);
        do_pop  = (m_count != 0) && !st;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) dropped = sb.pop_front();
            if (do_push) sb.push_back({pc, ins});
        end
        m_count = sb.size();
        @(posedge clk); #1;
        f_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid got=%b exp=0", d_valid); else n_pass++;
        n_checks++; if (f_ready !== 1'b1) $display("FAIL reset_f_ready got=%b exp=1", f_ready); else n_pass++;
        n_checks++; if (d_op !== 6'd0) $display("FAIL reset_d_op got=%h exp=0", d_op); else n_pass++;
        n_checks++; if (d_imm_sext !== 32'd0) $display("FAIL reset_sext got=%h exp=0", d_imm_sext); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_fields();
        step(1'b1, 32'h3000, 32'h8C28FFFC, 1'b1, 1'b0);
        n_checks++; if (d_valid !== 1'b1) $display("FAIL fld_d_valid got=%b exp=1", d_valid); else n_pass++;
        n_checks++; if (d_pc !== 32'h3000) $display("FAIL fld_pc got=%h exp=3000", d_pc); else n_pass++;
        n_checks++; if (d_op !== 6'h23) $display("FAIL fld_op got=%h exp=23", d_op); else n_pass++;
        n_checks++; if (d_rs !== 5'd1) $display("FAIL fld_rs got=%0d exp=1", d_rs); else n_pass++;
        n_checks++; if (d_rt !== 5'd8) $display("FAIL fld_rt got=%0d exp=8", d_rt); else n_pass++;
        n_checks++; if (d_rd !== 5'd31) $display("FAIL fld_rd got=%0d exp=31", d_rd); else n_pass++;
        n_checks++; if (d_shamt !== 5'd31) $display("FAIL fld_shamt got=%0d exp=31", d_shamt); else n_pass++;
        n_checks++; if (d_func !== 6'h3C) $display("FAIL fld_func got=%h exp=3c", d_func); else n_pass++;
        n_checks++; if (d_imm16 !== 16'hFFFC) $display("FAIL fld_imm16 got=%h exp=fffc", d_imm16); else n_pass++;
        n_checks++; if (d_imm26 !== 26'h028FFFC) $display("FAIL fld_imm26 got=%h exp=028fffc", d_imm26); else n_pass++;
        n_checks++; if (d_imm_sext !== 32'hFFFFFFFC) $display("FAIL fld_sext got=%h exp=fffffffc", d_imm_sext); else n_pass++;
        n_checks++; if (d_imm_zext !== 32'h0000FFFC) $display("FAIL fld_zext got=%h exp=0000fffc", d_imm_zext); else n_pass++;
        n_checks++; if (count !== 3'd1) $display("FAIL fld_count got=%0d exp=1", count); else n_pass++;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        n_checks++; if (count !== 3'd0) $display("FAIL fld_clear_count got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (f_ready !== (m_count != DEPTH))
                $display("FAIL full_f_ready[%0d] got=%b exp=%b", i, f_ready, (m_count != DEPTH));
            else n_pass++;
            step(1'b1, 32'h100 + 32'(4 * i), 32'h20000000 + 32'(i), 1'b1, 1'b0);
        end
        n_checks++; if (f_ready !== 1'b0) $display("FAIL full_f_ready_end got=%b exp=0", f_ready); else n_pass++;
        n_checks++; if (count !== 3'd4) $display("FAIL full_count got=%0d exp=4", count); else n_pass++;
        n_checks++; if (d_pc !== 32'h100) $display("FAIL full_head_pc got=%h exp=100", d_pc); else n_pass++;
        n_checks++; if (d_instr !== 32'h20000000) $display("FAIL full_head_instr got=%h exp=20000000", d_instr); else n_pass++;
    endtask

    task automatic test_drain_wrap();
        int          k = 0;
        logic [63:0] exp_head;
        for (int c = 0; c < 10; c++) begin
            exp_head = sb[0];
            n_checks++;
            if ({d_pc, d_instr} !== exp_head)
                $display("FAIL wrap_head[%0d] got=%h_%h exp=%h", c, d_pc, d_instr, exp_head);
            else n_pass++;
            if (m_count != DEPTH) begin
                step(1'b1, 32'h200 + 32'(4 * k), 32'h8C000000 + 32'(k), 1'b0, 1'b0);
                k++;
            end else begin
                step(1'b1, 32'h200 + 32'(4 * k), 32'h8C000000 + 32'(k), 1'b0, 1'b0);
            end
            n_checks++;
            if (count !== CNT_W'(m_count) || count !== 3'd3)
                $display("FAIL wrap_count[%0d] got=%0d exp=3", c, count);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        step(1'b1, 32'hDEAD0000, 32'h12345678, 1'b0, 1'b1);
        n_checks++; if (count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL flush_d_valid got=%b exp=0", d_valid); else n_pass++;
        n_checks++; if (d_pc !== 32'd0 || d_instr !== 32'd0) $display("FAIL flush_fields got=%h_%h exp=0", d_pc, d_instr); else n_pass++;
        n_checks++; if (f_ready !== 1'b1) $display("FAIL flush_f_ready got=%b exp=1", f_ready); else n_pass++;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd0) $display("FAIL flush_hold_count got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h400, 32'hAAAA0001, 1'b1, 1'b0);
        step(1'b1, 32'h404, 32'hAAAA0002, 1'b1, 1'b0);
        n_checks++; if (count !== 3'd2) $display("FAIL arst_pre_count got=%0d exp=2", count); else n_pass++;
        reset = 1'b0;
        #1;
        sb.delete(); m_count = 0;
        n_checks++; if (count !== 3'd0) $display("FAIL arst_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("FAIL arst_d_valid got=%b exp=0", d_valid); else n_pass++;
        n_checks++; if (f_ready !== 1'b1) $display("FAIL arst_f_ready got=%b exp=1", f_ready); else n_pass++;
        n_checks++; if (d_instr !== 32'd0) $display("FAIL arst_d_instr got=%h exp=0", d_instr); else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        step(1'b1, 32'h500, 32'hBBBB0005, 1'b1, 1'b0);
        n_checks++; if ({d_pc, d_instr} !== sb[0]) $display("FAIL arst_new_head got=%h_%h exp=%h", d_pc, d_instr, sb[0]); else n_pass++;
        n_checks++; if (count !== 3'd1) $display("FAIL arst_new_count got=%0d exp=1", count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fields();
        test_full();
        test_drain_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
